// File: rtl/bp_pkg.sv
// Shared types for the fetch-side branch predictor: counter encoding,
// table entry layout and the saturating counter step.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_ALLOC = WT;
    localparam ctr_e CTR_JAL   = ST;
    localparam ctr_e CTR_RESET = WNT;

    // Tag is sized for the smallest legal table (2 entries); larger tables
    // leave the upper tag bits zero.
    localparam int TAG_W = 30;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        ctr_e             ctr;
        logic [31:0]      target;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic ctr_e sat_update(input ctr_e ctr, input logic taken);
        ctr_e r;
        r = ctr;
        if (taken && ctr != ST) begin
            r = ctr_e'(ctr + 2'd1);
        end else if (!taken && ctr != SNT) begin
            r = ctr_e'(ctr - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped predictor storage: one asynchronous read port for IF,
// one synchronous write port for ID-stage updates, cleared on reset.
module bp_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IDX    = $clog2(ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [IDX-1:0]     rd_idx_i,
    output logic [ENTRY_W-1:0] rd_entry_o,
    input  logic               we_i,
    input  logic [IDX-1:0]     wr_idx_i,
    input  logic [ENTRY_W-1:0] wr_entry_i
);

    entry_t mem_q [ENTRIES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '{valid: 1'b0, tag: '0, ctr: CTR_RESET, target: '0};
            end
        end else if (we_i) begin
            mem_q[wr_idx_i] <= entry_t'(wr_entry_i);
        end
    end

    assign rd_entry_o = mem_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor with ID-stage mispredict detection, redirect
// generation, table update and performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic        if_valid,
    input  logic        stall,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        id_branch,
    input  logic        id_is_jal,
    input  logic        id_taken,
    input  logic [31:0] id_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
);

    localparam int IDX = $clog2(ENTRIES);

    logic [IDX-1:0]     if_idx;
    logic [TAG_W-1:0]   if_tag;
    logic [ENTRY_W-1:0] rd_bits;
    entry_t             rd_e;
    logic               if_hit;

    logic               we;
    logic [IDX-1:0]     wr_idx;
    entry_t             wr_e;
    entry_t             cap_e;

    logic               v_q, v_d;
    logic [31:0]        pc_q, pc_d;
    logic               pt_q, pt_d;
    logic [31:0]        ptgt_q, ptgt_d;
    entry_t             ent_q, ent_d;

    logic [31:0]        branch_cnt_q, branch_cnt_d;
    logic [31:0]        miss_cnt_q, miss_cnt_d;

    logic               res_active;
    logic               upd;
    logic [TAG_W-1:0]   id_tag;
    logic               id_hit;

    bp_table #(.ENTRIES(ENTRIES)) u_table (
        .clk_i      (clk),
        .rst_ni     (rst),
        .rd_idx_i   (if_idx),
        .rd_entry_o (rd_bits),
        .we_i       (we),
        .wr_idx_i   (wr_idx),
        .wr_entry_i (wr_e)
    );

    assign if_idx      = if_pc[IDX+1:2];
    assign if_tag      = {{IDX{1'b0}}, if_pc[31:IDX+2]};
    assign rd_e        = entry_t'(rd_bits);
    assign if_hit      = rd_e.valid && (rd_e.tag == if_tag);
    assign pred_taken  = if_hit && rd_e.ctr[1];
    assign pred_target = pred_taken ? rd_e.target : 32'd0;

    assign res_active  = v_q && id_branch;
    assign upd         = res_active && !stall;
    assign id_tag      = {{IDX{1'b0}}, pc_q[31:IDX+2]};
    assign id_hit      = ent_q.valid && (ent_q.tag == id_tag);
    assign wr_idx      = pc_q[IDX+1:2];

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = 32'd0;
        if (res_active) begin
            if (pt_q && !id_taken) begin
                mispredict  = 1'b1;
                redirect_pc = pc_q + 32'd4;
            end else if (id_taken && (!pt_q || ptgt_q != id_target)) begin
                mispredict  = 1'b1;
                redirect_pc = id_target;
            end
        end
    end

    always_comb begin
        we   = 1'b0;
        wr_e = ent_q;
        if (upd) begin
            if (id_hit) begin
                we       = 1'b1;
                wr_e.ctr = sat_update(ent_q.ctr, id_taken);
                if (id_taken) begin
                    wr_e.target = id_target;
                end
            end else if (id_taken) begin
                we   = 1'b1;
                wr_e = '{valid: 1'b1, tag: id_tag, ctr: CTR_ALLOC, target: id_target};
            end
            if (id_is_jal) begin
                wr_e.ctr = CTR_JAL;
            end
        end
    end

    // The entry copy carried into ID must reflect a write landing on the
    // same index in the same edge, since the async read still shows the old value.
    assign cap_e = (we && wr_idx == if_idx) ? wr_e : rd_e;

    always_comb begin
        v_d          = v_q;
        pc_d         = pc_q;
        pt_d         = pt_q;
        ptgt_d       = ptgt_q;
        ent_d        = ent_q;
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (!stall) begin
            v_d    = if_valid && !mispredict;
            pc_d   = if_pc;
            pt_d   = pred_taken;
            ptgt_d = pred_target;
            ent_d  = cap_e;
        end
        if (upd) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (mispredict) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q          <= 1'b0;
            pc_q         <= 32'd0;
            pt_q         <= 1'b0;
            ptgt_q       <= 32'd0;
            ent_q        <= '0;
            branch_cnt_q <= 32'd0;
            miss_cnt_q   <= 32'd0;
        end else begin
            v_q          <= v_d;
            pc_q         <= pc_d;
            pt_q         <= pt_d;
            ptgt_q       <= ptgt_d;
            ent_q        <= ent_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule
